// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller and its safety monitor.
// Holds the lamp bit layout, the fixed lamp patterns, the fault codes and the
// monitor state encoding.
package traffic_pkg;

  // Lamp vector layout: [5:3] road A {red, amber, green}, [2:0] road B.
  localparam int A_RED = 5;
  localparam int A_AMB = 4;
  localparam int A_GRN = 3;
  localparam int B_RED = 2;
  localparam int B_AMB = 1;
  localparam int B_GRN = 0;

  localparam logic [5:0] ALL_RED     = 6'b100_100;
  localparam logic [5:0] FLASH_AMBER = 6'b010_010;
  localparam logic [5:0] LAMPS_OFF   = 6'b000_000;

  typedef enum logic [2:0] {
    FC_NONE        = 3'd0,
    FC_ILLEGAL     = 3'd1,
    FC_CONFLICT    = 3'd2,
    FC_SHORT_GREEN = 3'd3,
    FC_STUCK       = 3'd4
  } fault_code_e;

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_MONITOR,
    ST_FAULT
  } mon_state_e;

  // Result of the combinational check stage.
  typedef struct packed {
    logic        fire;
    fault_code_e code;
  } check_t;

  // True when exactly one lamp of a road is lit.
  function automatic logic one_lamp(input logic [2:0] road);
    return (road == 3'b001) || (road == 3'b010) || (road == 3'b100);
  endfunction

endpackage

// File: rtl/light_flash_gen.sv
// Fault flash phase generator.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : flash enable; while low the generator sits at the start
//                    of an on-phase, so it restarts on-phase when enable rises
//   o_flash_on     : 1 during the on half-period, 0 during the off half
// The phase toggles after FLASH_HALF enabled cycles.
module light_flash_gen #(
  parameter int FLASH_HALF = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_flash_on
);

  localparam int CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt        <= '0;
      o_flash_on <= 1'b1;
    end else if (!i_en) begin
      cnt        <= '0;
      o_flash_on <= 1'b1;
    end else if (cnt == CW'(FLASH_HALF - 1)) begin
      cnt        <= '0;
      o_flash_on <= ~o_flash_on;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Safety monitor downstream of the traffic light controller.
// Passes legal lamp patterns to the lamp drivers two edges after they arrive,
// and on an illegal aspect, conflict, short green or stuck pattern latches a
// fault code and flashes amber on both roads until a qualified clear.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_light[5:0]   : lamp vector from the controller
//   i_clear        : fault clear request, honoured only while r_light is all-red
//   o_lamp[5:0]    : lamp drive
//   o_fault        : high while faulted
//   o_fault_code   : 0 none, 1 illegal, 2 conflict, 3 short green, 4 stuck
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 3,
  parameter int MAX_HOLD   = 64,
  parameter int FLASH_HALF = 4,
  parameter int STARTUP    = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_light,
  input  logic       i_clear,
  output logic [5:0] o_lamp,
  output logic       o_fault,
  output logic [2:0] o_fault_code
);

  localparam int DW = $clog2(MAX_HOLD + 1);
  localparam int SW = (STARTUP > 0) ? $clog2(STARTUP + 1) : 1;

  logic [5:0]    r_light, prev_light;
  logic [DW-1:0] dwell, dwell_nxt, prev_dwell;
  logic [SW-1:0] start_cnt;
  mon_state_e    state;
  check_t        chk;
  logic          conflict, illegal, green_fell, short_green, stuck;
  logic          clear_ok, flash_en, flash_on;

  // Dwell = consecutive edges r_light has held its value, saturating.
  always_comb begin
    dwell_nxt = dwell;
    if (i_light != r_light)
      dwell_nxt = DW'(1);
    else if (dwell != DW'(MAX_HOLD))
      dwell_nxt = dwell + DW'(1);
  end

  // prev_light/prev_dwell remember the pattern that r_light just replaced and
  // how long it was held, so a green turning off can be judged by the length
  // of the green it ended.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_light    <= ALL_RED;
      prev_light <= ALL_RED;
      dwell      <= '0;
      prev_dwell <= '0;
    end else begin
      r_light    <= i_light;
      prev_light <= r_light;
      prev_dwell <= dwell;
      dwell      <= clear_ok ? DW'(1) : dwell_nxt;
    end
  end

  always_comb begin
    conflict    = !r_light[A_RED] && !r_light[B_RED];
    illegal     = !one_lamp(r_light[A_RED:A_GRN]) || !one_lamp(r_light[B_RED:B_GRN]);
    green_fell  = (prev_light[A_GRN] && !r_light[A_GRN]) ||
                  (prev_light[B_GRN] && !r_light[B_GRN]);
    short_green = green_fell && (prev_dwell < DW'(MIN_GREEN));
    // Fires on the edge that would take the dwell count to MAX_HOLD, so the
    // stuck pattern never reaches the lamps for a MAX_HOLD-th cycle.
    stuck       = (dwell_nxt == DW'(MAX_HOLD));

    chk = '{fire: 1'b0, code: FC_NONE};
    if (conflict)         chk = '{fire: 1'b1, code: FC_CONFLICT};
    else if (illegal)     chk = '{fire: 1'b1, code: FC_ILLEGAL};
    else if (short_green) chk = '{fire: 1'b1, code: FC_SHORT_GREEN};
    else if (stuck)       chk = '{fire: 1'b1, code: FC_STUCK};
  end

  assign clear_ok = (state == ST_FAULT) && i_clear && (r_light == ALL_RED);

  // Enabled from the fault entry edge, so the entry edge is the first
  // on-phase cycle; dropped on clear so the next fault starts fresh.
  assign flash_en = ((state == ST_MONITOR) && chk.fire) ||
                    ((state == ST_FAULT) && !clear_ok);

  light_flash_gen #(.FLASH_HALF(FLASH_HALF)) u_flash (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_en      (flash_en),
    .o_flash_on(flash_on)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_STARTUP;
      start_cnt    <= '0;
      o_lamp       <= ALL_RED;
      o_fault      <= 1'b0;
      o_fault_code <= FC_NONE;
    end else begin
      case (state)
        ST_STARTUP: begin
          o_lamp <= ALL_RED;
          if (start_cnt == SW'(STARTUP - 1))
            state <= ST_MONITOR;
          else
            start_cnt <= start_cnt + SW'(1);
        end
        ST_MONITOR: begin
          if (chk.fire) begin
            state        <= ST_FAULT;
            o_fault      <= 1'b1;
            o_fault_code <= chk.code;
            o_lamp       <= FLASH_AMBER;
          end else begin
            o_lamp <= r_light;
          end
        end
        ST_FAULT: begin
          if (clear_ok) begin
            state        <= ST_MONITOR;
            o_lamp       <= ALL_RED;
            o_fault      <= 1'b0;
            o_fault_code <= FC_NONE;
          end else begin
            o_lamp <= flash_on ? FLASH_AMBER : LAMPS_OFF;
          end
        end
        default: state <= ST_STARTUP;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

  localparam int MIN_GREEN  = 3;
  localparam int MAX_HOLD   = 64;
  localparam int FLASH_HALF = 4;
  localparam int STARTUP    = 2;
  localparam logic [5:0] ALL_RED = 6'b100_100;
  localparam logic [5:0] FLASH   = 6'b010_010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] i_light;
  logic       i_clear;
  logic [5:0] o_lamp;
  logic       o_fault;
  logic [2:0] o_fault_code;

  traffic_light_monitor #(
    .MIN_GREEN(MIN_GREEN), .MAX_HOLD(MAX_HOLD),
    .FLASH_HALF(FLASH_HALF), .STARTUP(STARTUP)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_light(i_light), .i_clear(i_clear),
    .o_lamp(o_lamp), .o_fault(o_fault), .o_fault_code(o_fault_code)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // History of every captured lamp vector since reset release, indexed by
  // edge number; rules are evaluated by looking back through the history.
  logic [5:0] cap [0:4095];
  int         n;          // edges since reset release
  int         floor_e;    // edge of last clear (runs never span it)
  bit         in_fault;
  int         entry_e;
  int         fcode;
  logic [5:0] e_lamp;
  logic       e_fault;
  logic [2:0] e_code;

  function automatic int run_len(input int j);
    int k, c;
    c = 0;
    k = j;
    while (k >= 1 && k >= floor_e && cap[k] == cap[j] && c < MAX_HOLD) begin
      c++;
      k--;
    end
    return c;
  endfunction

  task automatic model_reset();
    n = 0; cap[0] = ALL_RED; floor_e = 1; in_fault = 0; entry_e = 0; fcode = 0;
  endtask

  task automatic model_edge(input logic clr);
    logic [5:0] rl, pl;
    bit conf, ill, sg, st;
    int code;
    if (n <= STARTUP) begin
      e_lamp = ALL_RED; e_fault = 0; e_code = 0;
    end else if (!in_fault) begin
      rl   = cap[n-1];
      pl   = cap[n-2];
      conf = !rl[5] && !rl[2];
      ill  = ($countones(rl[5:3]) != 1) || ($countones(rl[2:0]) != 1);
      sg   = ((pl[3] && !rl[3]) || (pl[0] && !rl[0])) && (run_len(n-2) < MIN_GREEN);
      st   = run_len(n) >= MAX_HOLD;
      code = conf ? 2 : ill ? 1 : sg ? 3 : st ? 4 : 0;
      if (code != 0) begin
        in_fault = 1; entry_e = n; fcode = code;
        e_lamp = FLASH; e_fault = 1; e_code = 3'(code);
      end else begin
        e_lamp = rl; e_fault = 0; e_code = 0;
      end
    end else if (clr && cap[n-1] == ALL_RED) begin
      in_fault = 0; floor_e = n;
      e_lamp = ALL_RED; e_fault = 0; e_code = 0;
    end else begin
      e_lamp  = (((n - entry_e) / FLASH_HALF) % 2 == 0) ? FLASH : 6'b000_000;
      e_fault = 1;
      e_code  = 3'(fcode);
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [5:0] lamp, input logic f,
                       input logic [2:0] c);
    checks++;
    if (o_lamp !== lamp || o_fault !== f || o_fault_code !== c) begin
      errors++;
      $display("FAIL %s edge %0d: got lamp=%b fault=%b code=%0d, want lamp=%b fault=%b code=%0d",
               name, n, o_lamp, o_fault, o_fault_code, lamp, f, c);
    end
  endtask

  // Drive one cycle of inputs, take the edge, advance the model, sample at +1.
  task automatic step(input logic [5:0] light, input logic clr);
    i_light = light;
    i_clear = clr;
    @(posedge clk);
    n++;
    cap[n] = light;
    model_edge(clr);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; i_light = ALL_RED; i_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", ALL_RED, 1'b0, 3'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [5:0] light;
    logic       clr;
    logic [5:0] lamp;
    logic       fault;
    logic [2:0] code;
  } vec_t;

  vec_t tbl [27];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] pat;
    logic [5:0] legal [5];
    int hold;

    // startup, conflict + flash cadence, clear qualification,
    // short green, then a green held exactly MIN_GREEN
    tbl[0]  = '{6'b001_100, 1'b0, 6'b100_100, 1'b0, 3'd0};
    tbl[1]  = '{6'b001_100, 1'b0, 6'b100_100, 1'b0, 3'd0};
    tbl[2]  = '{6'b001_100, 1'b0, 6'b001_100, 1'b0, 3'd0};
    tbl[3]  = '{6'b001_001, 1'b0, 6'b001_100, 1'b0, 3'd0};
    tbl[4]  = '{6'b100_001, 1'b0, 6'b010_010, 1'b1, 3'd2};
    tbl[5]  = '{6'b100_001, 1'b0, 6'b010_010, 1'b1, 3'd2};
    tbl[6]  = '{6'b100_001, 1'b0, 6'b010_010, 1'b1, 3'd2};
    tbl[7]  = '{6'b100_001, 1'b0, 6'b010_010, 1'b1, 3'd2};
    tbl[8]  = '{6'b001_100, 1'b0, 6'b000_000, 1'b1, 3'd2};
    tbl[9]  = '{6'b001_100, 1'b1, 6'b000_000, 1'b1, 3'd2};
    tbl[10] = '{6'b100_100, 1'b0, 6'b000_000, 1'b1, 3'd2};
    tbl[11] = '{6'b100_100, 1'b0, 6'b000_000, 1'b1, 3'd2};
    tbl[12] = '{6'b100_100, 1'b0, 6'b010_010, 1'b1, 3'd2};
    tbl[13] = '{6'b100_100, 1'b1, 6'b100_100, 1'b0, 3'd0};
    tbl[14] = '{6'b100_100, 1'b0, 6'b100_100, 1'b0, 3'd0};
    tbl[15] = '{6'b001_100, 1'b0, 6'b100_100, 1'b0, 3'd0};
    tbl[16] = '{6'b001_100, 1'b0, 6'b001_100, 1'b0, 3'd0};
    tbl[17] = '{6'b010_100, 1'b0, 6'b001_100, 1'b0, 3'd0};
    tbl[18] = '{6'b010_100, 1'b0, 6'b010_010, 1'b1, 3'd3};
    tbl[19] = '{6'b100_100, 1'b0, 6'b010_010, 1'b1, 3'd3};
    tbl[20] = '{6'b100_100, 1'b1, 6'b100_100, 1'b0, 3'd0};
    tbl[21] = '{6'b001_100, 1'b0, 6'b100_100, 1'b0, 3'd0};
    tbl[22] = '{6'b001_100, 1'b0, 6'b001_100, 1'b0, 3'd0};
    tbl[23] = '{6'b001_100, 1'b0, 6'b001_100, 1'b0, 3'd0};
    tbl[24] = '{6'b010_100, 1'b0, 6'b001_100, 1'b0, 3'd0};
    tbl[25] = '{6'b100_100, 1'b0, 6'b010_100, 1'b0, 3'd0};
    tbl[26] = '{6'b100_100, 1'b0, 6'b100_100, 1'b0, 3'd0};

    legal[0] = 6'b100_100; legal[1] = 6'b001_100; legal[2] = 6'b010_100;
    legal[3] = 6'b100_001; legal[4] = 6'b100_010;

    do_reset();

    for (int i = 0; i < 27; i++) begin
      step(tbl[i].light, tbl[i].clr);
      check("table", tbl[i].lamp, tbl[i].fault, tbl[i].code);
      check("table_model", e_lamp, e_fault, e_code);
    end

    // stuck: 64 identical cycles fault on the 64th
    for (int k = 1; k <= 64; k++) begin
      step(6'b100_001, 1'b0);
      check("stuck_model", e_lamp, e_fault, e_code);
      if (k == 63) check("stuck_pre", 6'b100_001, 1'b0, 3'd0);
      if (k == 64) check("stuck_fire", FLASH, 1'b1, 3'd4);
    end
    step(6'b100_100, 1'b0);
    step(6'b100_100, 1'b1);
    check("stuck_clear", ALL_RED, 1'b0, 3'd0);

    // 63 identical cycles then a change: no fault
    for (int k = 1; k <= 63; k++) begin
      step(6'b100_001, 1'b0);
      check("hold63_model", e_lamp, e_fault, e_code);
    end
    step(6'b100_100, 1'b0);
    check("hold63_last", 6'b100_001, 1'b0, 3'd0);
    step(6'b100_100, 1'b0);
    check("hold63_after", 6'b100_100, 1'b0, 3'd0);

    // illegal + conflict together: conflict wins
    step(6'b011_000, 1'b0);
    check("prio_pre", 6'b100_100, 1'b0, 3'd0);
    step(6'b100_100, 1'b0);
    check("prio_code", FLASH, 1'b1, 3'd2);
    step(6'b100_100, 1'b0);
    check("prio_hold", FLASH, 1'b1, 3'd2);

    // asynchronous reset in the middle of a flash cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", ALL_RED, 1'b0, 3'd0);
    do_reset();

    // randomized traffic against the model
    pat = ALL_RED;
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        if ($urandom_range(19) == 0) pat = 6'($urandom);
        else pat = legal[$urandom_range(4)];
        hold = ($urandom_range(39) == 0) ? $urandom_range(70, 60) : $urandom_range(6, 1);
      end
      step(pat, ($urandom_range(3) == 0));
      check("random", e_lamp, e_fault, e_code);
      hold--;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
